// File: rtl/servo_pulse_gen.sv
// servo_pulse_gen
//
// Servo-drive timing block.
//  - Fixed-period PWM on `signal`. The high time is W0/W1/W2 cycles for
//    sel = 0/1/2. sel = 3 holds the output low.
//  - Free-running timebase: `clk_out` toggles every HALF_SEC_CYC cycles.
//    `tick` is high for the single cycle in which `clk_out` has just gone high.
//
// Ports:
//   clk      in   system clock; every register uses the rising edge
//   rst_n    in   asynchronous, active-low reset
//   sel[1:0] in   speed select (0/1/2 = W0/W1/W2, 3 = off)
//   signal   out  registered PWM output
//   clk_out  out  registered square wave, period 2*HALF_SEC_CYC
//   tick     out  one-cycle pulse on each rising transition of clk_out
//
// Build option:
//   SERVO_SEL_LATCH_EN
//     Defined:   sel is sampled only at period start (pwm_cnt == 0).
//                Pulses are therefore never truncated or stretched.
//     Undefined: sel acts on the very next edge.
//
// There are no handshakes and no FSM. The counters are the only state.

module servo_pulse_gen #(
  parameter int PERIOD_CYC   = 1_000_000,
  parameter int W0_CYC       = 50_000,
  parameter int W1_CYC       = 75_000,
  parameter int W2_CYC       = 100_000,
  parameter int HALF_SEC_CYC = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sel,
  output logic       signal,
  output logic       clk_out,
  output logic       tick
);

  // The counter width is clamped to at least 1 bit so that a bound of 1 still builds.
  localparam int PW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int DW = (HALF_SEC_CYC > 1) ? $clog2(HALF_SEC_CYC) : 1;
  // A width may equal PERIOD_CYC, so the comparison needs one more value than the counter holds.
  localparam int WW = $clog2(PERIOD_CYC + 1);

  localparam logic [PW-1:0] PWM_LAST = PW'(PERIOD_CYC - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF_SEC_CYC - 1);
  localparam logic [WW-1:0] W0       = WW'(W0_CYC);
  localparam logic [WW-1:0] W1       = WW'(W1_CYC);
  localparam logic [WW-1:0] W2       = WW'(W2_CYC);

  // ---------------------------------------------------------------------------
  // PWM period counter
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pwm_cnt_q, pwm_cnt_d;
  logic          pwm_at_zero;

  assign pwm_at_zero = (pwm_cnt_q == '0);

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    if (pwm_cnt_q == PWM_LAST) pwm_cnt_d = '0;
  end

  // ---------------------------------------------------------------------------
  // Effective select
  // ---------------------------------------------------------------------------
  logic [1:0] sel_eff;

`ifdef SERVO_SEL_LATCH_EN
  logic [1:0] sel_q, sel_d;

  // On the first cycle of a period the live input is used directly.
  // That value is captured here and held for the rest of the period.
  always_comb begin
    sel_d = sel_q;
    if (pwm_at_zero) sel_d = sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_q <= 2'd3;
    else        sel_q <= sel_d;
  end

  assign sel_eff = pwm_at_zero ? sel : sel_q;
`else
  assign sel_eff = sel;
`endif

  // ---------------------------------------------------------------------------
  // Width decode and PWM output
  // ---------------------------------------------------------------------------
  logic [WW-1:0] active_w;
  logic          signal_q, signal_d;

  always_comb begin
    active_w = '0;
    case (sel_eff)
      2'd0:    active_w = W0;
      2'd1:    active_w = W1;
      2'd2:    active_w = W2;
      default: active_w = '0;
    endcase
  end

  // The counter value is taken before the increment. The output therefore lags the counter by one edge.
  assign signal_d = (WW'(pwm_cnt_q) < active_w);

  // ---------------------------------------------------------------------------
  // Timebase divider
  // ---------------------------------------------------------------------------
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          div_wrap;
  logic          clk_out_q, clk_out_d;
  logic          tick_q, tick_d;

  assign div_wrap = (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (div_wrap) div_cnt_d = '0;
  end

  assign clk_out_d = clk_out_q ^ div_wrap;
  // tick marks the cycle that clk_out spends as a freshly risen 1.
  assign tick_d    = div_wrap & ~clk_out_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      signal_q  <= 1'b0;
      div_cnt_q <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      signal_q  <= signal_d;
      div_cnt_q <= div_cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign signal  = signal_q;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_servo_pulse_gen.sv
// Testbench for servo_pulse_gen.
//
// dut_a uses the standard test parameters: PERIOD = 100, W0/W1/W2 = 5/8/10, HALF = 20.
// dut_f uses the same parameters except W2 = 100, so sel = 2 on this
// instance gives a full-width pulse.
//
// A reference model predicts every output after every edge from the number
// of edges since reset release:
//   pos     = (k-1) mod PERIOD
//   signal  = pos < width(select)
//   clk_out = floor(k/HALF) is odd
//   tick    = k mod 2*HALF == HALF

module tb_servo_pulse_gen;

  localparam int PERIOD = 100;
  localparam int W0     = 5;
  localparam int W1     = 8;
  localparam int W2     = 10;
  localparam int HALF   = 20;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUTs
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sel;
  logic       signal_a, clk_out_a, tick_a;
  logic       signal_f, clk_out_f, tick_f;

  always #5 clk = ~clk;

  servo_pulse_gen #(
    .PERIOD_CYC(PERIOD), .W0_CYC(W0), .W1_CYC(W1), .W2_CYC(W2), .HALF_SEC_CYC(HALF)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .sel(sel),
    .signal(signal_a), .clk_out(clk_out_a), .tick(tick_a)
  );

  servo_pulse_gen #(
    .PERIOD_CYC(PERIOD), .W0_CYC(W0), .W1_CYC(W1), .W2_CYC(PERIOD), .HALF_SEC_CYC(HALF)
  ) dut_f (
    .clk(clk), .rst_n(rst_n), .sel(sel),
    .signal(signal_f), .clk_out(clk_out_f), .tick(tick_f)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;
  int k     = 0;   // edges since reset release
`ifdef SERVO_SEL_LATCH_EN
  logic [1:0] period_sel = 2'd3;
`endif

  typedef struct {
    logic [1:0] sel;
    int         periods;
    int         exp_high;
  } seg_t;

  seg_t tbl[6];

  function automatic int width_of(logic [1:0] s, int w2);
    case (s)
      2'd0:    return W0;
      2'd1:    return W1;
      2'd2:    return w2;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, k);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, k);
    end
  endtask

  // Advance one edge and compare all outputs against the model.
  // sel must stay stable between the edge and the sample taken here.
  task automatic step();
    int         pos;
    logic [1:0] eff;
    @(posedge clk);
    #1;
    k++;
    pos = (k - 1) % PERIOD;
`ifdef SERVO_SEL_LATCH_EN
    if (pos == 0) period_sel = sel;
    eff = period_sel;
`else
    eff = sel;
`endif
    check("signal",      signal_a,  logic'(pos < width_of(eff, W2)));
    check("signal_full", signal_f,  logic'(pos < width_of(eff, PERIOD)));
    check("clk_out",     clk_out_a, logic'(((k / HALF) % 2) == 1));
    check("tick",        tick_a,    logic'((k % (2 * HALF)) == HALF));
    check("clk_out_f",   clk_out_f, logic'(((k / HALF) % 2) == 1));
    check("tick_f",      tick_f,    logic'((k % (2 * HALF)) == HALF));
  endtask

  // Assert reset right now (away from an edge), confirm it acts without a
  // clock, hold it 10 cycles with sel = 2, then release.
  task automatic do_reset();
    sel   = 2'd2;
    rst_n = 1'b0;
    #1;
    check("rst_async_signal",   signal_a, 1'b0);
    check("rst_async_signal_f", signal_f, 1'b0);
    repeat (10) begin
      @(posedge clk);
      #1;
      check("rst_signal",  signal_a,  1'b0);
      check("rst_clk_out", clk_out_a, 1'b0);
      check("rst_tick",    tick_a,    1'b0);
      check("rst_signal_f", signal_f, 1'b0);
    end
    rst_n = 1'b1;
    k     = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int hi;
    int lo_f;
    int ticks;
    int first_tick;
    int exp_mid;

    tbl[0] = '{sel: 2'd0, periods: 3, exp_high: W0};
    tbl[1] = '{sel: 2'd1, periods: 3, exp_high: W1};
    tbl[2] = '{sel: 2'd2, periods: 3, exp_high: W2};
    tbl[3] = '{sel: 2'd3, periods: 3, exp_high: 0};
    tbl[4] = '{sel: 2'd2, periods: 1, exp_high: W2};
    tbl[5] = '{sel: 2'd0, periods: 1, exp_high: W0};

    rst_n = 1'b0;
    sel   = 2'd2;
    do_reset();

    // Table: per-period pulse widths. Each segment starts on a period boundary.
    foreach (tbl[i]) begin
      sel = tbl[i].sel;
      for (int p = 0; p < tbl[i].periods; p++) begin
        hi   = 0;
        lo_f = 0;
        repeat (PERIOD) begin
          step();
          hi   += int'(signal_a);
          lo_f += int'(!signal_f);
        end
        check_int("pulse_width", hi, tbl[i].exp_high);
        if (tbl[i].sel == 2'd2) check_int("full_width_lows", lo_f, 0);
      end
    end

    // Mid-period change: sel goes 0 -> 2 once three edges of the period have passed.
`ifdef SERVO_SEL_LATCH_EN
    exp_mid = W0;
`else
    exp_mid = W2;
`endif
    sel = 2'd0;
    hi  = 0;
    repeat (3) begin
      step();
      hi += int'(signal_a);
    end
    sel = 2'd2;
    repeat (PERIOD - 3) begin
      step();
      hi += int'(signal_a);
    end
    check_int("mid_change_cur", hi, exp_mid);
    hi = 0;
    repeat (PERIOD) begin
      step();
      hi += int'(signal_a);
    end
    check_int("mid_change_next", hi, W2);

    // Reset asserted between edges while the pulse is high.
    sel = 2'd2;
    step();
    step();
    #3;
    do_reset();

    // Divider from a fresh release: ticks at 20, 60, 100, 140, 180.
    sel        = 2'd1;
    ticks      = 0;
    first_tick = -1;
    repeat (200) begin
      step();
      if (tick_a) begin
        ticks++;
        if (first_tick < 0) first_tick = k;
      end
    end
    check_int("tick_count", ticks, 5);
    check_int("first_tick", first_tick, HALF);

    // Random select changes at arbitrary points in the period.
    for (int s = 0; s < 30; s++) begin
      sel = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 250)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
